// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit pipelined MIPS core.
//   WORD_W   : instruction/data word width
//   ADDR_W   : word-address width
//   RESET_PC : program counter value after reset
//   fetch_state_e : instruction-fetch refill FSM states
package mips_pkg;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    UPDATE
  } fetch_state_e;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: per-line valid bit and tag, plus
// a LINES*LINE_WORDS x WORD_W data array. One combinational read port and
// one synchronous write port (word write during refill, line commit after).
// Ports:
//   clk, rst_n   : clock, async active-low reset (clears valid bits only)
//   rd_index/rd_offset -> rd_valid, rd_tag, rd_data : combinational lookup
//   wr_data_en   : write wr_data into word [wr_index][wr_offset]
//   wr_line_en   : set valid[wr_index] and store wr_tag
module icache_array
  import mips_pkg::*;
#(
  parameter  int LINES      = 8,
  parameter  int LINE_WORDS = 4,
  localparam int IDX_W      = $clog2(LINES),
  localparam int OFF_W      = $clog2(LINE_WORDS),
  localparam int TAG_W      = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [OFF_W-1:0]  rd_offset,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [WORD_W-1:0] rd_data,
  input  logic              wr_data_en,
  input  logic              wr_line_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [OFF_W-1:0]  wr_offset,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag
);
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WORD_W-1:0] data_q [LINES*LINE_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_line_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags and data are guarded by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_line_en) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_data_en) begin
      data_q[{wr_index, wr_offset}] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_offset}];
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: program counter, direct-mapped I-cache lookup
// and a word-serial line refill from instruction memory.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   stall               : hold the PC
//   redirect/redirect_pc: taken branch/jump target (word address)
//   pc_plus1            : PC + 1 (modulo 2^16)
//   instruction         : cached word at the PC
//   hit_fetch           : instruction valid, IF/ID capture enable
//   mem_req/mem_addr    : refill word request and address
//   mem_ack/mem_rdata   : one-cycle refill acknowledge with data
// Build option FETCH_PERF_CNT_EN adds saturating outputs perf_hits
// (cycles with hit_fetch) and perf_misses (refills started).
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic [WORD_W-1:0] instruction,
  output logic              hit_fetch,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_hits,
  output logic [15:0]       perf_misses
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_data_en, wr_line_en;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic              hit;

  icache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_icache_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (pc_q[OFF_W +: IDX_W]),
    .rd_offset  (pc_q[OFF_W-1:0]),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (instruction),
    .wr_data_en (wr_data_en),
    .wr_line_en (wr_line_en),
    .wr_index   (base_q[OFF_W +: IDX_W]),
    .wr_offset  (cnt_q),
    .wr_data    (mem_rdata),
    .wr_tag     (base_q[ADDR_W-1 -: TAG_W])
  );

  assign hit       = rd_valid && (rd_tag == pc_q[ADDR_W-1 -: TAG_W]);
  assign hit_fetch = hit && (state_q == IDLE) && !stall;
  assign pc_plus1  = pc_q + 1'b1;
  // Driven straight from the state register so reset drops the request at once.
  assign mem_req   = (state_q == REFILL);
  assign mem_addr  = mem_req ? (base_q | ADDR_W'(cnt_q)) : '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    base_d     = base_q;
    wr_data_en = 1'b0;
    wr_line_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          // A taken redirect makes the missing fetch irrelevant: skip the refill.
          if (redirect && !stall) begin
            pc_d = redirect_pc;
          end else begin
            state_d = REFILL;
            cnt_d   = '0;
            base_d  = {pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end else if (!stall) begin
          pc_d = redirect ? redirect_pc : pc_plus1;
        end
      end
      REFILL: begin
        if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (mem_ack) begin
          wr_data_en = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        wr_line_en = 1'b1;
        state_d    = IDLE;
        pend_d     = 1'b0;
        // A redirect arriving in this last cycle is the newest target.
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (pend_q) begin
          pc_d = pend_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q    <= base_d;
    pend_pc_q <= pend_pc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (hit_fetch && (perf_hits != 16'hFFFF)) begin
        perf_hits <= perf_hits + 1'b1;
      end
      if ((state_q == IDLE) && (state_d == REFILL) && (perf_misses != 16'hFFFF)) begin
        perf_misses <= perf_misses + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit (default build, LINES=8, LINE_WORDS=4).
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] pc_plus1;
  logic [15:0] instruction;
  logic        hit_fetch;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  inst_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_plus1    (pc_plus1),
    .instruction (instruction),
    .hit_fetch   (hit_fetch),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Memory responder: data = address ^ mem_key, acked always or randomly.
  logic [15:0] mem_key = 16'h0;
  bit ack_rand = 1'b0;
  bit noise = 1'b0;
  initial forever begin
    @(negedge clk);
    if (mem_req) mem_ack = ack_rand ? ($urandom_range(0, 9) < 6) : 1'b1;
    else         mem_ack = noise && ($urandom_range(0, 3) == 0);
    mem_rdata = (mem_ack && mem_req) ? (mem_addr ^ mem_key) : 16'($urandom);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cache contents as line numbers per set, pending refill
  // as a queue of word addresses still to be fetched.
  int          m_line [8];
  logic [15:0] m_data [32];
  logic [15:0] m_pc;
  logic [15:0] m_q [$];
  bit          m_refill;
  bit          m_pend;
  logic [15:0] m_pend_pc;
  bit          prev_req;
  int          req_rises;

  task automatic model_reset();
    foreach (m_line[i]) m_line[i] = -1;
    m_pc = 16'h0;
    m_q.delete();
    m_refill = 1'b0;
    m_pend = 1'b0;
    prev_req = 1'b0;
    req_rises = 0;
  endtask

  task automatic model_cycle();
    logic [15:0] p1;
    logic [15:0] base;
    int ix;
    bit h;
    bit busy;
    p1 = m_pc + 16'd1;
    ix = (int'(m_pc) / 4) % 8;
    h = !m_refill && (m_line[ix] == int'(m_pc) / 4);
    busy = m_refill && (m_q.size() > 0);
    chk("pc_plus1", pc_plus1, p1);
    chk("hit_fetch", 16'(hit_fetch), 16'(h && !stall));
    chk("mem_req", 16'(mem_req), 16'(busy));
    chk("mem_addr", mem_addr, busy ? m_q[0] : 16'h0);
    if (h) chk("instruction", instruction, m_data[int'(m_pc) % 32]);
    if (!m_refill) begin
      if (h) begin
        if (!stall) m_pc = redirect ? redirect_pc : p1;
      end else if (redirect && !stall) begin
        m_pc = redirect_pc;
      end else begin
        base = m_pc & 16'hFFFC;
        for (int k = 0; k < 4; k++) m_q.push_back(base + 16'(k));
        m_refill = 1'b1;
      end
    end else if (busy) begin
      if (redirect) begin
        m_pend = 1'b1;
        m_pend_pc = redirect_pc;
      end
      if (mem_ack) begin
        m_data[int'(m_q[0]) % 32] = mem_rdata;
        void'(m_q.pop_front());
      end
    end else begin
      m_line[ix] = int'(m_pc) / 4;
      m_refill = 1'b0;
      if (redirect) m_pc = redirect_pc;
      else if (m_pend) m_pc = m_pend_pc;
      m_pend = 1'b0;
    end
  endtask

  // Drive one cycle's inputs on the falling edge and sample just after.
  task automatic step(input logic s, input logic r, input logic [15:0] rp);
    @(negedge clk);
    stall = s;
    redirect = r;
    redirect_pc = rp;
    #1;
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
  endtask

  task automatic mstep(input logic s, input logic r, input logic [15:0] rp);
    step(s, r, rp);
    model_cycle();
  endtask

  // Assert reset asynchronously right now, check outputs, release after a posedge.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_hit_fetch", 16'(hit_fetch), 16'h0);
    chk("rst_pc_plus1", pc_plus1, 16'h1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [15:0] rp;
    logic        hf;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] p1;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cold start from PC 0, always-acking memory with data = address.
    tbl[0]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1};
    tbl[1]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h1};
    tbl[2]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1, 16'h0, 16'h1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h2, 16'h0, 16'h1};
    tbl[4]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h3, 16'h0, 16'h1};
    tbl[5]  = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1};
    tbl[6]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h1, 16'h2};
    tbl[8]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h2, 16'h3};
    tbl[9]  = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h3, 16'h4};
    tbl[10] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5};
    tbl[11] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4, 16'h0, 16'h5};
    tbl[12] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5, 16'h0, 16'h5};
    tbl[13] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h6, 16'h0, 16'h5};
    tbl[14] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h7, 16'h0, 16'h5};
    tbl[15] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5};
    tbl[16] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h4, 16'h5};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].s, tbl[i].r, tbl[i].rp);
      chk($sformatf("vec%0d_hit_fetch", i), 16'(hit_fetch), 16'(tbl[i].hf));
      chk($sformatf("vec%0d_mem_req", i), 16'(mem_req), 16'(tbl[i].req));
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("vec%0d_pc_plus1", i), pc_plus1, tbl[i].p1);
      if (tbl[i].hf) chk($sformatf("vec%0d_instruction", i), instruction, tbl[i].instr);
    end

    // Tag conflict: 0 and 0x20 share set 0 and evict each other.
    do_reset();
    repeat (9) mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b1, 16'h0020);
    repeat (6) mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b1, 16'h0000);
    repeat (7) mstep(1'b0, 1'b0, 16'h0);
    chk("conflict_refills", 16'(req_rises), 16'd3);
    chk("conflict_rehit", 16'(hit_fetch), 16'h1);

    // Redirect while hitting: at PC 2 jump back to 1.
    do_reset();
    repeat (8) mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b1, 16'h0001);
    mstep(1'b0, 1'b0, 16'h0);
    chk("redir_hit", 16'(hit_fetch), 16'h1);
    chk("redir_instr", instruction, 16'h0001);
    chk("redir_pc_plus1", pc_plus1, 16'h0002);

    // Stall three cycles at PC 2, then resume there.
    for (int i = 0; i < 3; i++) begin
      mstep(1'b1, 1'b0, 16'h0);
      chk("stall_hit_fetch", 16'(hit_fetch), 16'h0);
      chk("stall_pc_plus1", pc_plus1, 16'h0003);
    end
    mstep(1'b0, 1'b0, 16'h0);
    chk("stall_resume_instr", instruction, 16'h0002);

    // Redirect mid-refill: line 4..7 still fills, then PC goes to 0x100.
    mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b1, 16'h0100);
    repeat (3) mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b0, 16'h0);
    chk("midref_pc_plus1", pc_plus1, 16'h0101);
    chk("midref_miss", 16'(hit_fetch), 16'h0);
    repeat (5) mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b1, 16'h0004);
    mstep(1'b0, 1'b0, 16'h0);
    chk("midref_line_hit", 16'(hit_fetch), 16'h1);
    chk("midref_line_instr", instruction, 16'h0004);

    // PC wrap at 0xFFFF.
    mstep(1'b0, 1'b1, 16'hFFFC);
    repeat (6) mstep(1'b0, 1'b0, 16'h0);
    repeat (3) mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b0, 16'h0);
    chk("wrap_pc_plus1", pc_plus1, 16'h0000);
    chk("wrap_instr", instruction, 16'hFFFF);
    mstep(1'b0, 1'b0, 16'h0);
    chk("wrap_next_pc", pc_plus1, 16'h0001);

    // Reset in the middle of a refill forces a cold miss afterwards.
    mstep(1'b0, 1'b1, 16'h0040);
    mstep(1'b0, 1'b0, 16'h0);
    mstep(1'b0, 1'b0, 16'h0);
    chk("pre_reset_req", 16'(mem_req), 16'h1);
    do_reset();
    mstep(1'b0, 1'b0, 16'h0);
    chk("post_reset_cold_miss", 16'(hit_fetch), 16'h0);
    repeat (6) mstep(1'b0, 1'b0, 16'h0);

    // Randomized traffic against the model.
    mem_key = 16'h5A3C;
    ack_rand = 1'b1;
    noise = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic s;
      logic r;
      logic [15:0] rp;
      s = ($urandom_range(0, 9) < 2);
      r = ($urandom_range(0, 9) == 0);
      rp = ($urandom_range(0, 9) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15)))
                                       : 16'($urandom_range(0, 127));
      mstep(s, r, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
